// File: rtl/mdu_unit_if.sv
// ---------------------------------------------------------------------------
// | mdu_unit_if : operand, control and result bundle of the multiply/divide   |
// | unit.                                                                     |
// | Rev 1.0                                                                   |
// ---------------------------------------------------------------------------
`default_nettype none

interface mdu_unit_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input Busy, Stall, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, Stall, HI, LO);
endinterface

`default_nettype wire

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// | mdu_unit : multi-cycle multiply/divide unit with HI/LO registers.         |
// | Optional madd (MDUOp 7) is built when MDU_MADD_EN is defined.             |
// | Rev 1.0                                                                   |
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mdu_unit_if.slave   bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_pend_wr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [63:0]      w_smul, w_umul;
  logic             w_b_nz;
  logic [31:0]      w_b_safe, w_a_mag, w_b_mag;
  logic [31:0]      w_sq_mag, w_sr_mag, w_squo, w_srem, w_uquo, w_urem;
  logic             w_is_multi, w_res_wr;
  logic [CNT_W-1:0] w_load;
  logic [63:0]      w_res;

  assign w_smul = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign w_umul = {32'd0, bus.A} * {32'd0, bus.B};

  // Divisor forced to 1 on divide-by-zero; the result is discarded anyway.
  assign w_b_nz   = (bus.B != 32'd0);
  assign w_b_safe = w_b_nz ? bus.B : 32'd1;
  assign w_uquo   = bus.A / w_b_safe;
  assign w_urem   = bus.A % w_b_safe;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  assign w_a_mag  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign w_b_mag  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_squo   = (bus.A[31] ^ w_b_safe[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
  assign w_srem   = bus.A[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

  always_comb begin
    w_is_multi = 1'b0;
    w_res_wr   = 1'b1;
    w_load     = MULT_LOAD;
    w_res      = 64'd0;
    case (bus.MDUOp)
      OP_MULT: begin
        w_is_multi = 1'b1;
        w_res      = w_smul;
      end
      OP_MULTU: begin
        w_is_multi = 1'b1;
        w_res      = w_umul;
      end
      OP_DIV: begin
        w_is_multi = 1'b1;
        w_load     = DIV_LOAD;
        w_res      = {w_srem, w_squo};
        w_res_wr   = w_b_nz;
      end
      OP_DIVU: begin
        w_is_multi = 1'b1;
        w_load     = DIV_LOAD;
        w_res      = {w_urem, w_uquo};
        w_res_wr   = w_b_nz;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        w_is_multi = 1'b1;
        w_res      = {r_hi, r_lo} + w_smul;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        r_busy <= 1'b0;
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end else if (bus.Start) begin
      if (w_is_multi) begin
        r_pend_hi <= w_res[63:32];
        r_pend_lo <= w_res[31:0];
        r_pend_wr <= w_res_wr;
        r_cnt     <= w_load;
        r_busy    <= 1'b1;
      end else if (bus.MDUOp == OP_MTHI) begin
        r_hi <= bus.A;
      end else if (bus.MDUOp == OP_MTLO) begin
        r_lo <= bus.A;
      end
    end
  end

  assign bus.Busy  = r_busy;
  assign bus.Stall = r_busy | (bus.Start & w_is_multi);
  assign bus.HI    = r_hi;
  assign bus.LO    = r_lo;

endmodule

`default_nettype wire
